// File: rtl/pipeline_pkg.sv
// Shared types and constants for the LEGv8 pipeline registers.
package pipeline_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       ALUSrc;
    logic [2:0] ALUOp;
    logic       Branch;
    logic       UncondBr;
  } ctrl_t;

  localparam logic [4:0] XZR      = 5'd31;
  localparam ctrl_t      CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] ONE = 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbles
// and saturating stall/flush event counters.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [4:0]    id_rn,
  input  logic [4:0]    id_rm,
  input  logic [4:0]    id_rd,
  input  logic          id_reads_rd,
  input  ctrl_t         id_ctrl,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc,
  input  logic          ex_flush,
  output logic          idex_valid,
  output logic [4:0]    idex_rn,
  output logic [4:0]    idex_rm,
  output logic [4:0]    idex_rd,
  output ctrl_t         idex_ctrl,
  output logic [DW-1:0] idex_rdata1,
  output logic [DW-1:0] idex_rdata2,
  output logic [DW-1:0] idex_imm,
  output logic [DW-1:0] idex_pc,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          stall,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  logic          valid_q, valid_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [4:0]    rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic [DW-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [DW-1:0] imm_q, imm_d, pc_q, pc_d;
  logic          load_use;

  // A load into XZR never produces a value, so it cannot cause a hazard.
  assign load_use = valid_q && ctrl_q.MemRead && (rd_q != XZR) && id_valid &&
                    ((rd_q == id_rn) || (rd_q == id_rm) ||
                     (id_reads_rd && (rd_q == id_rd)));

  assign stall      = load_use && !ex_flush;
  assign pc_write   = !stall;
  assign ifid_write = !stall;

  always_comb begin
    valid_d  = id_valid;
    ctrl_d   = id_valid ? id_ctrl : CTRL_NOP;
    rn_d     = id_valid ? id_rn : XZR;
    rm_d     = id_valid ? id_rm : XZR;
    rd_d     = id_valid ? id_rd : XZR;
    rdata1_d = id_rdata1;
    rdata2_d = id_rdata2;
    imm_d    = id_imm;
    pc_d     = id_pc;
    // Bubbles carry Rd=XZR and no control so forwarding never matches them.
    if (ex_flush || stall) begin
      valid_d  = 1'b0;
      ctrl_d   = CTRL_NOP;
      rn_d     = XZR;
      rm_d     = XZR;
      rd_d     = XZR;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      pc_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_NOP;
      rn_q     <= XZR;
      rm_q     <= XZR;
      rd_q     <= XZR;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
    end
  end

  assign idex_valid  = valid_q;
  assign idex_ctrl   = ctrl_q;
  assign idex_rn     = rn_q;
  assign idex_rm     = rm_q;
  assign idex_rd     = rd_q;
  assign idex_rdata1 = rdata1_q;
  assign idex_rdata2 = rdata2_q;
  assign idex_imm    = imm_q;
  assign idex_pc     = pc_q;

  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_flush),
    .count (flush_cnt)
  );

endmodule
